branch_resolve_unit: RTL and testbench

Multi-lane branch resolution stage in the execute pipeline. It resolves up to `LANES` control-flow instructions per cycle and selects the oldest mispredict. That mispredict is held as a redirect request, with a valid/ready handshake, until the frontend accepts it. Resolved outcomes, with updated saturating counters, are buffered in an update FIFO that drains one entry per cycle to the branch predictor.

---
 rtl/branch_resolve_unit.sv | 175 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Multi-lane branch resolution: oldest-mispredict redirect with valid/ready
// handshake and an update FIFO draining resolved outcomes to the predictor.
module branch_resolve_unit #(
   parameter int LANES = 2,
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int CW    = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic [LANES-1:0]          in_valid,
   output logic                      in_ready,
   input  logic [LANES-1:0][3:0]     in_kind,
   input  logic [LANES-1:0][AW-1:0]  in_reg1,
   input  logic [LANES-1:0][AW-1:0]  in_reg2,
   input  logic [LANES-1:0][AW-1:0]  in_pc,
   input  logic [LANES-1:0][AW-1:0]  in_imm_target,
   input  logic [LANES-1:0]          pred_valid,
   input  logic [LANES-1:0]          pred_taken,
   input  logic [LANES-1:0][AW-1:0]  pred_target,
   input  logic [LANES-1:0][CW-1:0]  pred_counter,
   output logic                      redirect_valid,
   input  logic                      redirect_ready,
   output logic [AW-1:0]             redirect_pc,
   output logic                      upd_valid,
   input  logic                      upd_ready,
   output logic [AW-1:0]             upd_pc,
   output logic [AW-1:0]             upd_target,
   output logic                      upd_taken,
   output logic                      upd_mispredict,
   output logic [CW-1:0]             upd_counter
);

   localparam int PW = $clog2(DEPTH);
   localparam int NW = PW + 1;

   typedef enum logic {IDLE, PEND} state_t;

   state_t state_q, state_d;

   logic [AW-1:0] mem_pc  [DEPTH];
   logic [AW-1:0] mem_tgt [DEPTH];
   logic          mem_tk  [DEPTH];
   logic          mem_mis [DEPTH];
   logic [CW-1:0] mem_cnt [DEPTH];

   logic [PW-1:0] head_q, tail_q;
   logic [NW-1:0] count_q;
   logic          init_q;
   logic [AW-1:0] rpc_q;

   logic [LANES-1:0]         is_c, is_j, tk, mis, surv;
   logic [LANES-1:0][AW-1:0] tgt;
   logic [LANES-1:0][CW-1:0] cnt_new;
   logic [LANES-1:0][PW-1:0] wr_idx;
   logic [NW-1:0]            off;
   logic                     stop;
   logic [AW-1:0]            rd_pc;
   logic                     accept, pop;
   logic [NW-1:0]            free;

   always_comb begin
      is_c    = '0;
      is_j    = '0;
      tk      = '0;
      mis     = '0;
      surv    = '0;
      tgt     = '0;
      cnt_new = '0;
      wr_idx  = '0;
      off     = '0;
      stop    = 1'b0;
      rd_pc   = '0;
      for (int i = 0; i < LANES; i++) begin
         case (in_kind[i])
            4'd1: begin is_c[i] = 1'b1; tk[i] = in_reg1[i] == in_reg2[i]; end
            4'd2: begin is_c[i] = 1'b1; tk[i] = in_reg1[i] != in_reg2[i]; end
            4'd3: begin
               is_c[i] = 1'b1;
               tk[i]   = (in_reg1[i] == '0) | in_reg1[i][AW-1];
            end
            4'd4: begin
               is_c[i] = 1'b1;
               tk[i]   = (in_reg1[i] != '0) & ~in_reg1[i][AW-1];
            end
            4'd5: begin is_c[i] = 1'b1; tk[i] = in_reg1[i][AW-1]; end
            4'd6: begin is_c[i] = 1'b1; tk[i] = ~in_reg1[i][AW-1]; end
            4'd7, 4'd8: begin is_j[i] = 1'b1; tk[i] = 1'b1; end
            default: ;
         endcase
         tgt[i] = (in_kind[i] == 4'd8) ? in_reg1[i] : in_imm_target[i];
         if (is_j[i])
            mis[i] = ~pred_valid[i] | ~pred_taken[i] | (pred_target[i] != tgt[i]);
         else if (is_c[i])
            mis[i] = pred_valid[i]
                   ? ((pred_taken[i] != tk[i]) | (tk[i] & (pred_target[i] != tgt[i])))
                   : tk[i];
         if (tk[i])
            cnt_new[i] = (pred_counter[i] == '1) ? pred_counter[i]
                                                 : pred_counter[i] + CW'(1);
         else
            cnt_new[i] = (pred_counter[i] == '0) ? pred_counter[i]
                                                 : pred_counter[i] - CW'(1);
         // Lanes younger than the first mispredict are wrong-path.
         surv[i]   = in_valid[i] & (is_c[i] | is_j[i]) & ~stop;
         wr_idx[i] = tail_q + off[PW-1:0];
         if (surv[i]) off = off + NW'(1);
         if (surv[i] & mis[i]) begin
            stop  = 1'b1;
            rd_pc = tk[i] ? tgt[i] : in_pc[i] + AW'(8);
         end
      end
   end

   assign free     = NW'(DEPTH) - count_q;
   assign in_ready = init_q & (free >= NW'(LANES)) & (state_q == IDLE);
   assign accept   = (|in_valid) & in_ready & ~flush;
   assign upd_valid = count_q != '0;
   assign pop      = upd_valid & upd_ready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept & stop) state_d = PEND;
         PEND: if (redirect_ready | flush) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         init_q  <= 1'b0;
         rpc_q   <= '0;
         for (int j = 0; j < DEPTH; j++) begin
            mem_pc[j]  <= '0;
            mem_tgt[j] <= '0;
            mem_tk[j]  <= 1'b0;
            mem_mis[j] <= 1'b0;
            mem_cnt[j] <= '0;
         end
      end else begin
         state_q <= state_d;
         init_q  <= 1'b1;
         if (state_q == IDLE && state_d == PEND) rpc_q <= rd_pc;
         if (accept) begin
            for (int i = 0; i < LANES; i++) begin
               if (surv[i]) begin
                  mem_pc[wr_idx[i]]  <= in_pc[i];
                  mem_tgt[wr_idx[i]] <= tgt[i];
                  mem_tk[wr_idx[i]]  <= tk[i];
                  mem_mis[wr_idx[i]] <= mis[i];
                  mem_cnt[wr_idx[i]] <= cnt_new[i];
               end
            end
            tail_q <= tail_q + off[PW-1:0];
         end
         if (pop) head_q <= head_q + PW'(1);
         count_q <= count_q + (accept ? off : '0) - (pop ? NW'(1) : '0);
      end
   end

   assign redirect_valid = state_q == PEND;
   assign redirect_pc    = rpc_q;
   assign upd_pc         = mem_pc[head_q];
   assign upd_target     = mem_tgt[head_q];
   assign upd_taken      = mem_tk[head_q];
   assign upd_mispredict = mem_mis[head_q];
   assign upd_counter    = mem_cnt[head_q];

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, hand sequences,
// and random traffic against a queue-based reference model.
module tb_branch_resolve_unit;

   localparam int LANES = 2;
   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int CW    = 2;

   logic clk = 1'b0;
   logic rst_n, flush;
   logic [LANES-1:0] in_valid;
   logic in_ready;
   logic [LANES-1:0][3:0] in_kind;
   logic [LANES-1:0][AW-1:0] in_reg1, in_reg2, in_pc, in_imm_target;
   logic [LANES-1:0] pred_valid, pred_taken;
   logic [LANES-1:0][AW-1:0] pred_target;
   logic [LANES-1:0][CW-1:0] pred_counter;
   logic redirect_valid, redirect_ready;
   logic [AW-1:0] redirect_pc;
   logic upd_valid, upd_ready;
   logic [AW-1:0] upd_pc, upd_target;
   logic upd_taken, upd_mispredict;
   logic [CW-1:0] upd_counter;

   branch_resolve_unit #(.LANES(LANES), .DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
      .in_reg1(in_reg1), .in_reg2(in_reg2), .in_pc(in_pc),
      .in_imm_target(in_imm_target),
      .pred_valid(pred_valid), .pred_taken(pred_taken),
      .pred_target(pred_target), .pred_counter(pred_counter),
      .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
      .redirect_pc(redirect_pc),
      .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
      .upd_mispredict(upd_mispredict), .upd_counter(upd_counter)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [AW-1:0] pc, tgt;
      logic tk, mis;
      int cnt;
   } ent_t;

   ent_t mq[$];
   logic mrv;
   logic [AW-1:0] mpc;
   logic m_init;

   typedef struct {
      logic [1:0] vld, pv, pt;
      logic [1:0][3:0] kind;
      logic [1:0][31:0] r1, r2, pc, imm, ptgt;
      logic [1:0][1:0] cnt;
      logic e_rv;
      logic [31:0] e_rpc;
      int e_n;
      logic e_t0, e_m0;
      logic [1:0] e_c0;
   } vec_t;

   vec_t vt[6];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic m_ready();
      return m_init && (DEPTH - mq.size() >= LANES) && !mrv;
   endfunction

   task automatic model_step();
      logic acc;
      acc = (|in_valid) && m_ready() && !flush;
      if (mq.size() > 0 && upd_ready) void'(mq.pop_front());
      if (mrv && (redirect_ready || flush)) mrv = 1'b0;
      if (acc) begin
         for (int i = 0; i < LANES; i++) begin
            int k, c;
            logic t, ms;
            logic [AW-1:0] tg;
            k = int'(in_kind[i]);
            if (!in_valid[i] || k == 0 || k > 8) continue;
            case (k)
               1: t = in_reg1[i] == in_reg2[i];
               2: t = in_reg1[i] != in_reg2[i];
               3: t = $signed(in_reg1[i]) <= 0;
               4: t = $signed(in_reg1[i]) > 0;
               5: t = $signed(in_reg1[i]) < 0;
               6: t = $signed(in_reg1[i]) >= 0;
               default: t = 1'b1;
            endcase
            tg = (k == 8) ? in_reg1[i] : in_imm_target[i];
            if (k >= 7) ms = !pred_valid[i] || !pred_taken[i] || pred_target[i] != tg;
            else if (pred_valid[i]) ms = (pred_taken[i] != t) || (t && pred_target[i] != tg);
            else ms = t;
            c = int'(pred_counter[i]);
            c = t ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
            mq.push_back('{pc: in_pc[i], tgt: tg, tk: t, mis: ms, cnt: c});
            if (ms) begin
               mrv = 1'b1;
               mpc = t ? tg : in_pc[i] + 32'd8;
               break;
            end
         end
      end
      m_init = 1'b1;
   endtask

   task automatic compare_outputs();
      chk("redirect_valid", redirect_valid, mrv);
      if (mrv) chk("redirect_pc", redirect_pc, mpc);
      chk("upd_valid", upd_valid, mq.size() > 0);
      if (mq.size() > 0) begin
         chk("upd_pc", upd_pc, mq[0].pc);
         chk("upd_target", upd_target, mq[0].tgt);
         chk("upd_taken", upd_taken, mq[0].tk);
         chk("upd_mispredict", upd_mispredict, mq[0].mis);
         chk("upd_counter", upd_counter, mq[0].cnt[1:0]);
      end
   endtask

   task automatic cycle();
      chk("in_ready", in_ready, m_ready());
      model_step();
      @(posedge clk);
      #1;
      compare_outputs();
   endtask

   task automatic clear_in();
      in_valid = '0; in_kind = '0; in_reg1 = '0; in_reg2 = '0;
      in_pc = '0; in_imm_target = '0; pred_valid = '0; pred_taken = '0;
      pred_target = '0; pred_counter = '0; flush = 0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      clear_in();
      redirect_ready = 0; upd_ready = 0;
      mq.delete(); mrv = 0; mpc = '0; m_init = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst in_ready", in_ready, 1'b0);
      chk("rst redirect_valid", redirect_valid, 1'b0);
      chk("rst upd_valid", upd_valid, 1'b0);
      chk("rst redirect_pc", redirect_pc, 32'd0);
      #2 rst_n = 1;
   endtask

   function automatic logic [31:0] rop();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'd5;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         4: return 32'h100;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // vector table: kinds 1 BEQ 2 BNE 3 BLEZ 4 BGTZ 5 BLTZ 6 BGEZ 7 J 8 JR
      vt[0] = '{vld: 2'b01, pv: 2'b00, pt: 2'b00, kind: {4'd0, 4'd1},
                r1: {32'd0, 32'd5}, r2: {32'd0, 32'd5}, pc: {32'd0, 32'h40},
                imm: {32'd0, 32'h100}, ptgt: {32'd0, 32'd0}, cnt: {2'd0, 2'b01},
                e_rv: 1, e_rpc: 32'h100, e_n: 1, e_t0: 1, e_m0: 1, e_c0: 2'b10};
      vt[1] = '{vld: 2'b11, pv: 2'b11, pt: 2'b00, kind: {4'd5, 4'd2},
                r1: {32'h8000_0000, 32'd3}, r2: {32'd0, 32'd3},
                pc: {32'h84, 32'h80}, imm: {32'h400, 32'h90},
                ptgt: {32'd0, 32'd0}, cnt: {2'b01, 2'b01},
                e_rv: 1, e_rpc: 32'h400, e_n: 2, e_t0: 0, e_m0: 0, e_c0: 2'b00};
      vt[2] = '{vld: 2'b11, pv: 2'b01, pt: 2'b01, kind: {4'd1, 4'd8},
                r1: {32'd7, 32'h300}, r2: {32'd7, 32'd0}, pc: {32'h14, 32'h10},
                imm: {32'h50, 32'h0}, ptgt: {32'd0, 32'h200}, cnt: {2'd0, 2'b10},
                e_rv: 1, e_rpc: 32'h300, e_n: 1, e_t0: 1, e_m0: 1, e_c0: 2'b11};
      vt[3] = '{vld: 2'b11, pv: 2'b01, pt: 2'b01, kind: {4'd4, 4'd7},
                r1: {32'd0, 32'd9}, r2: {32'd0, 32'd0}, pc: {32'h24, 32'h20},
                imm: {32'h600, 32'h500}, ptgt: {32'd0, 32'h500}, cnt: {2'b00, 2'b11},
                e_rv: 0, e_rpc: 32'd0, e_n: 2, e_t0: 1, e_m0: 0, e_c0: 2'b11};
      vt[4] = '{vld: 2'b01, pv: 2'b01, pt: 2'b01, kind: {4'd0, 4'd3},
                r1: {32'd0, 32'd1}, r2: {32'd0, 32'd0}, pc: {32'd0, 32'hFFFF_FFFC},
                imm: {32'd0, 32'h700}, ptgt: {32'd0, 32'h700}, cnt: {2'd0, 2'b00},
                e_rv: 1, e_rpc: 32'h4, e_n: 1, e_t0: 0, e_m0: 1, e_c0: 2'b00};
      vt[5] = '{vld: 2'b11, pv: 2'b00, pt: 2'b00, kind: {4'd6, 4'd11},
                r1: {32'hFFFF_FFFF, 32'd0}, r2: {32'd0, 32'd0}, pc: {32'h34, 32'h30},
                imm: {32'h800, 32'h0}, ptgt: {32'd0, 32'd0}, cnt: {2'b10, 2'b00},
                e_rv: 0, e_rpc: 32'd0, e_n: 1, e_t0: 0, e_m0: 0, e_c0: 2'b01};

      do_reset();
      cycle();
      chk("in_ready after release", in_ready, 1'b1);

      for (int v = 0; v < 6; v++) begin
         int n;
         in_valid = vt[v].vld; in_kind = vt[v].kind;
         in_reg1 = vt[v].r1; in_reg2 = vt[v].r2; in_pc = vt[v].pc;
         in_imm_target = vt[v].imm; pred_valid = vt[v].pv;
         pred_taken = vt[v].pt; pred_target = vt[v].ptgt;
         pred_counter = vt[v].cnt;
         cycle();
         clear_in();
         chk($sformatf("vec%0d redirect_valid", v), redirect_valid, vt[v].e_rv);
         if (vt[v].e_rv) chk($sformatf("vec%0d redirect_pc", v), redirect_pc, vt[v].e_rpc);
         chk($sformatf("vec%0d upd_valid", v), upd_valid, 1'b1);
         chk($sformatf("vec%0d upd_taken", v), upd_taken, vt[v].e_t0);
         chk($sformatf("vec%0d upd_mispredict", v), upd_mispredict, vt[v].e_m0);
         chk($sformatf("vec%0d upd_counter", v), upd_counter, vt[v].e_c0);
         redirect_ready = 1; upd_ready = 1;
         n = 0;
         while (upd_valid && n < 8) begin
            n++;
            cycle();
         end
         chk($sformatf("vec%0d entries", v), n, vt[v].e_n);
         redirect_ready = 0; upd_ready = 0;
      end

      // fill the FIFO with two correctly predicted bundles, then drain
      for (int b = 0; b < 2; b++) begin
         in_valid = 2'b11; in_kind = {4'd1, 4'd1};
         in_reg1 = {32'd1, 32'd1}; in_reg2 = {32'd2, 32'd2};
         in_pc = {32'h1004 + 32'(8 * b), 32'h1000 + 32'(8 * b)};
         cycle();
         chk("fill in_ready", in_ready, b == 0);
      end
      clear_in();
      upd_ready = 1;
      for (int p = 0; p < 4; p++) begin
         chk("drain order", upd_pc, 32'h1000 + 32'(4 * p));
         cycle();
         if (p == 0) chk("in_ready at count 3", in_ready, 1'b0);
         if (p == 1) chk("in_ready at count 2", in_ready, 1'b1);
      end
      upd_ready = 0;

      // held redirect, then flush
      in_valid = 2'b01; in_kind = {4'd0, 4'd1};
      in_reg1 = {32'd0, 32'd3}; in_reg2 = {32'd0, 32'd3};
      in_pc = {32'd0, 32'h3000}; in_imm_target = {32'd0, 32'h2220};
      cycle();
      clear_in();
      for (int h = 0; h < 3; h++) begin
         chk("hold redirect_valid", redirect_valid, 1'b1);
         chk("hold redirect_pc", redirect_pc, 32'h2220);
         chk("hold in_ready", in_ready, 1'b0);
         cycle();
      end
      flush = 1;
      cycle();
      flush = 0;
      chk("flush redirect_valid", redirect_valid, 1'b0);
      chk("flush keeps fifo", upd_valid, 1'b1);
      chk("flush keeps entry", upd_pc, 32'h3000);

      // asynchronous reset with a non-empty FIFO
      #2 rst_n = 0;
      #1;
      chk("async rst upd_valid", upd_valid, 1'b0);
      chk("async rst in_ready", in_ready, 1'b0);
      chk("async rst upd_pc", upd_pc, 32'd0);
      do_reset();

      for (int c = 0; c < 1500; c++) begin
         in_valid = 2'($urandom);
         for (int i = 0; i < LANES; i++) begin
            in_kind[i] = 4'($urandom_range(0, 10));
            in_reg1[i] = rop();
            in_reg2[i] = rop();
            in_pc[i] = $urandom & 32'hFFFF_FFFC;
            in_imm_target[i] = $urandom_range(0, 1) ? 32'h100 : 32'h200;
            pred_valid[i] = 1'($urandom);
            pred_taken[i] = 1'($urandom);
            pred_target[i] = $urandom_range(0, 1) ? 32'h100 : 32'h200;
            pred_counter[i] = 2'($urandom);
         end
         flush = $urandom_range(0, 15) == 0;
         redirect_ready = 1'($urandom);
         upd_ready = $urandom_range(0, 3) != 0;
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
